alu_operand_stage: RTL and testbench

Registered, parametrised ALU operand-selection stage between ID and EX of the pipelined CPU. Each accepted instruction's register operands pass through optional EX/MEM and MEM/WB forwarding. The stage then forms ALU operands A and B from one of six source modes, adding LUI and illegal-mode detection to the existing five. Results are held in a one-deep valid/ready pipeline register with flush.

---
 rtl/alu_src_pkg.sv | 22 ++
 rtl/alu_operand_stage_if.sv | 58 +++++
 rtl/alu_operand_fwd.sv | 35 +++
 rtl/alu_operand_stage.sv | 144 ++++++++++++++
 tb/tb_alu_operand_stage.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_src_pkg.sv
// ALU operand-select types: source-mode encoding and legality check.
// Shared by the operand stage, its interface and forwarding unit.
package alu_src_pkg;

  localparam int SRC_CTRL_W = 3;

  typedef enum logic [SRC_CTRL_W-1:0] {
    SRC_RR   = 3'd0,
    SRC_IMMZ = 3'd1,
    SRC_IMMS = 3'd2,
    SRC_SHV  = 3'd3,
    SRC_SHC  = 3'd4,
    SRC_LUI  = 3'd5
  } src_ctrl_e;

  function automatic logic is_legal_src(
    input logic [SRC_CTRL_W-1:0] s
  );
    return s <= SRC_LUI;
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// ID -> operand stage -> EX bundle with forwarding sources.
// master drives instructions and out_ready; slave is the stage.
interface alu_operand_stage_if
  import alu_src_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int IMM_W   = 16,
  parameter int SHAMT_W = $clog2(XLEN),
  parameter int RADDR_W = 5
);

  logic                  in_valid;
  logic                  in_ready;
  logic [SRC_CTRL_W-1:0] src_ctrl;
  logic [RADDR_W-1:0]    rs_addr;
  logic [RADDR_W-1:0]    rt_addr;
  logic [XLEN-1:0]       reg_a;
  logic [XLEN-1:0]       reg_b;
  logic [SHAMT_W-1:0]    shamt;
  logic [IMM_W-1:0]      imm;
  logic                  exm_we;
  logic [RADDR_W-1:0]    exm_addr;
  logic [XLEN-1:0]       exm_data;
  logic                  wb_we;
  logic [RADDR_W-1:0]    wb_addr;
  logic [XLEN-1:0]       wb_data;
  logic                  flush;
  logic                  out_ready;
  logic                  out_valid;
  logic [XLEN-1:0]       out_a;
  logic [XLEN-1:0]       out_b;
  logic                  out_err;

  modport master (
    output in_valid, src_ctrl,
    output rs_addr, rt_addr,
    output reg_a, reg_b,
    output shamt, imm,
    output exm_we, exm_addr, exm_data,
    output wb_we, wb_addr, wb_data,
    output flush, out_ready,
    input  in_ready, out_valid,
    input  out_a, out_b, out_err
  );

  modport slave (
    input  in_valid, src_ctrl,
    input  rs_addr, rt_addr,
    input  reg_a, reg_b,
    input  shamt, imm,
    input  exm_we, exm_addr, exm_data,
    input  wb_we, wb_addr, wb_data,
    input  flush, out_ready,
    output in_ready, out_valid,
    output out_a, out_b, out_err
  );

endinterface

// File: rtl/alu_operand_fwd.sv
// Forwarding mux for one source operand.
// EX/MEM beats MEM/WB; register 0 is never forwarded.
module alu_operand_fwd #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] addr,
  input  logic [XLEN-1:0]    reg_data,
  input  logic               exm_we,
  input  logic [RADDR_W-1:0] exm_addr,
  input  logic [XLEN-1:0]    exm_data,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]    wb_data,
  output logic [XLEN-1:0]    data
);

  logic nz;
  logic exm_hit;
  logic wb_hit;

  assign nz      = addr != '0;
  assign exm_hit = exm_we && (exm_addr == addr) && nz;
  assign wb_hit  = wb_we && (wb_addr == addr) && nz;

  always_comb begin
    data = reg_data;
    if (exm_hit) begin
      data = exm_data;
    end else if (wb_hit) begin
      data = wb_data;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU operand select between ID and EX, one-deep skid-free.
// Define ALU_OPERAND_FWD_EN to enable EX/MEM and MEM/WB forwarding.
module alu_operand_stage
  import alu_src_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int IMM_W   = 16,
  parameter int SHAMT_W = $clog2(XLEN),
  parameter int RADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_operand_stage_if.slave io
);

  if (XLEN < IMM_W || (XLEN & (XLEN - 1)) != 0 ||
      SHAMT_W != $clog2(XLEN) || RADDR_W < 1) begin : g_bad_cfg
    $error("alu_operand_stage: bad parameters");
  end

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;

`ifdef ALU_OPERAND_FWD_EN
  alu_operand_fwd #(
    .XLEN   (XLEN),
    .RADDR_W(RADDR_W)
  ) u_fwd_rs (
    .addr    (io.rs_addr),
    .reg_data(io.reg_a),
    .exm_we  (io.exm_we),
    .exm_addr(io.exm_addr),
    .exm_data(io.exm_data),
    .wb_we   (io.wb_we),
    .wb_addr (io.wb_addr),
    .wb_data (io.wb_data),
    .data    (a)
  );

  alu_operand_fwd #(
    .XLEN   (XLEN),
    .RADDR_W(RADDR_W)
  ) u_fwd_rt (
    .addr    (io.rt_addr),
    .reg_data(io.reg_b),
    .exm_we  (io.exm_we),
    .exm_addr(io.exm_addr),
    .exm_data(io.exm_data),
    .wb_we   (io.wb_we),
    .wb_addr (io.wb_addr),
    .wb_data (io.wb_data),
    .data    (b)
  );
`else
  assign a = io.reg_a;
  assign b = io.reg_b;
`endif

  logic [XLEN-1:0] sel_a;
  logic [XLEN-1:0] sel_b;
  logic            sel_err;

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_err = !is_legal_src(io.src_ctrl);
    case (io.src_ctrl)
      SRC_RR: begin
        sel_a = a;
        sel_b = b;
      end
      SRC_IMMZ: begin
        sel_a = a;
        sel_b = XLEN'(io.imm);
      end
      SRC_IMMS: begin
        sel_a = a;
        sel_b = XLEN'($signed(io.imm));
      end
      SRC_SHV: begin
        sel_a = b;
        sel_b = XLEN'(a[SHAMT_W-1:0]);
      end
      SRC_SHC: begin
        sel_a = b;
        sel_b = XLEN'(io.shamt);
      end
      SRC_LUI: begin
        sel_b = XLEN'(io.imm) << (XLEN - IMM_W);
      end
      default: begin
        sel_a = '0;
        sel_b = '0;
      end
    endcase
  end

  logic            valid_q, valid_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            err_q, err_d;
  logic            xfer;

  assign io.in_ready = !valid_q || io.out_ready;
  assign xfer        = io.in_valid && io.in_ready;

  // flush wins over a same-edge transfer
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    if (io.flush) begin
      valid_d = 1'b0;
    end else if (xfer) begin
      valid_d = 1'b1;
      a_d     = sel_a;
      b_d     = sel_b;
      err_d   = sel_err;
    end else if (io.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
    end
  end

  assign io.out_valid = valid_q;
  assign io.out_a     = a_q;
  assign io.out_b     = b_q;
  assign io.out_err   = err_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage.
// Honors ALU_OPERAND_FWD_EN in its expectations.
module tb_alu_operand_stage;
  import alu_src_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        err;
  } exp_t;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        wwe;
    logic [4:0]  wa;
    logic [31:0] wd;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  alu_operand_stage_if io ();

  alu_operand_stage dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t mk(
    input logic [2:0]  src,
    input logic [31:0] ra,
    input logic [31:0] rb,
    input logic [4:0]  sh,
    input logic [15:0] imm
  );
    stim_t s;
    s.src = src; s.ra = ra; s.rb = rb;
    s.rs = 5'd1; s.rt = 5'd2;
    s.sh = sh; s.imm = imm;
    s.ewe = 1'b0; s.ea = 5'd0; s.ed = 32'd0;
    s.wwe = 1'b0; s.wa = 5'd0; s.wd = 32'd0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    io.in_valid = 1'b1;
    io.src_ctrl = s.src;
    io.reg_a = s.ra;
    io.reg_b = s.rb;
    io.rs_addr = s.rs;
    io.rt_addr = s.rt;
    io.shamt = s.sh;
    io.imm = s.imm;
    io.exm_we = s.ewe;
    io.exm_addr = s.ea;
    io.exm_data = s.ed;
    io.wb_we = s.wwe;
    io.wb_addr = s.wa;
    io.wb_data = s.wd;
  endtask

  function automatic logic [31:0] fwd_val(
    input logic [4:0]  r,
    input logic [31:0] rd
  );
`ifdef ALU_OPERAND_FWD_EN
    if (io.exm_we && io.exm_addr == r && r != 0)
      return io.exm_data;
    if (io.wb_we && io.wb_addr == r && r != 0)
      return io.wb_data;
`endif
    return rd;
  endfunction

  function automatic exp_t model();
    exp_t e;
    logic [31:0] a, b;
    a = fwd_val(io.rs_addr, io.reg_a);
    b = fwd_val(io.rt_addr, io.reg_b);
    e.a = 32'd0; e.b = 32'd0; e.err = 1'b0;
    case (io.src_ctrl)
      3'd0: begin e.a = a; e.b = b; end
      3'd1: begin e.a = a; e.b = {16'h0, io.imm}; end
      3'd2: begin
        e.a = a;
        e.b = {{16{io.imm[15]}}, io.imm};
      end
      3'd3: begin e.a = b; e.b = {27'd0, a[4:0]}; end
      3'd4: begin e.a = b; e.b = {27'd0, io.shamt}; end
      3'd5: e.b = {io.imm, 16'h0};
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    io.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(mk(3'($urandom_range(0, 7)), $urandom, $urandom,
               5'($urandom), 16'($urandom)));
      io.flush = 1'($urandom);
      tick();
      checks++;
      if (io.out_valid !== 1'b0 || io.out_a !== 32'd0 ||
          io.out_b !== 32'd0 || io.out_err !== 1'b0 ||
          io.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset[%0d]: got v=%b a=%h b=%h err=%b rdy=%b, want 0 0 0 0 1",
                 i, io.out_valid, io.out_a, io.out_b, io.out_err, io.in_ready);
      end
    end
    io.flush = 1'b0;
    io.out_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    drive(mk(3'd0, 32'd5, 32'd7, 5'd0, 16'd0));
    sb.push_back('{32'd5, 32'd7, 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if (io.out_valid !== 1'b1 || io.out_a !== e.a ||
        io.out_b !== e.b || io.out_err !== e.err) begin
      errors++;
      $display("FAIL reset_first: got v=%b a=%h b=%h err=%b, want v=1 a=%h b=%h err=%b",
               io.out_valid, io.out_a, io.out_b, io.out_err, e.a, e.b, e.err);
    end
    io.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_extension();
    stim_t s[3];
    exp_t  x[3];
    exp_t  e;
    s[0] = mk(3'd1, 32'h11, 32'h22, 5'd0, 16'h8001);
    x[0] = '{32'h11, 32'h0000_8001, 1'b0};
    s[1] = mk(3'd2, 32'h11, 32'h22, 5'd0, 16'h8001);
    x[1] = '{32'h11, 32'hFFFF_8001, 1'b0};
    s[2] = mk(3'd5, 32'h11, 32'h22, 5'd0, 16'h8001);
    x[2] = '{32'h0, 32'h8001_0000, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (io.out_valid !== 1'b1 || io.out_a !== e.a ||
          io.out_b !== e.b || io.out_err !== e.err) begin
        errors++;
        $display("FAIL ext[%0d]: got v=%b a=%h b=%h err=%b, want v=1 a=%h b=%h err=%b",
                 i, io.out_valid, io.out_a, io.out_b, io.out_err, e.a, e.b, e.err);
      end
    end
    io.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_shifts();
    stim_t s[4];
    exp_t  x[4];
    exp_t  e;
    s[0] = mk(3'd3, 32'h0000_0123, 32'hF0, 5'd3, 16'd0);
    x[0] = '{32'hF0, 32'd3, 1'b0};
    s[1] = mk(3'd4, 32'h0000_0123, 32'hF0, 5'd3, 16'd0);
    x[1] = '{32'hF0, 32'd3, 1'b0};
    s[2] = mk(3'd3, 32'hFFFF_FFF5, 32'hABCD, 5'd3, 16'd0);
    x[2] = '{32'hABCD, 32'h15, 1'b0};
    s[3] = mk(3'd4, 32'hFFFF_FFF5, 32'hABCD, 5'h1C, 16'd0);
    x[3] = '{32'hABCD, 32'h1C, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (io.out_valid !== 1'b1 || io.out_a !== e.a ||
          io.out_b !== e.b || io.out_err !== e.err) begin
        errors++;
        $display("FAIL shift[%0d]: got v=%b a=%h b=%h err=%b, want v=1 a=%h b=%h err=%b",
                 i, io.out_valid, io.out_a, io.out_b, io.out_err, e.a, e.b, e.err);
      end
    end
    io.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_forward();
    stim_t s[4];
    exp_t  x[4];
    exp_t  e;
    for (int i = 0; i < 4; i++) begin
      s[i] = mk(3'd0, 32'h100, 32'h200, 5'd0, 16'd0);
      s[i].ewe = 1'b1; s[i].ea = 5'd4; s[i].ed = 32'd9;
      s[i].wwe = 1'b1; s[i].wa = 5'd4; s[i].wd = 32'd8;
    end
    s[0].rs = 5'd4;
    s[1].rs = 5'd0;
    s[2].rs = 5'd4; s[2].ea = 5'd7;
    s[3].rs = 5'd4; s[3].rt = 5'd4; s[3].ewe = 1'b0;
`ifdef ALU_OPERAND_FWD_EN
    x[0] = '{32'd9, 32'h200, 1'b0};
    x[2] = '{32'd8, 32'h200, 1'b0};
    x[3] = '{32'd8, 32'd8, 1'b0};
`else
    x[0] = '{32'h100, 32'h200, 1'b0};
    x[2] = '{32'h100, 32'h200, 1'b0};
    x[3] = '{32'h100, 32'h200, 1'b0};
`endif
    x[1] = '{32'h100, 32'h200, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (io.out_valid !== 1'b1 || io.out_a !== e.a ||
          io.out_b !== e.b || io.out_err !== e.err) begin
        errors++;
        $display("FAIL fwd[%0d]: got v=%b a=%h b=%h err=%b, want v=1 a=%h b=%h err=%b",
                 i, io.out_valid, io.out_a, io.out_b, io.out_err, e.a, e.b, e.err);
      end
    end
    io.in_valid = 1'b0;
    drive(mk(3'd0, 32'd0, 32'd0, 5'd0, 16'd0));
    io.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    stim_t s[3];
    exp_t  x[3];
    exp_t  e;
    s[0] = mk(3'd6, 32'h1234, 32'h5678, 5'd9, 16'hFFFF);
    x[0] = '{32'd0, 32'd0, 1'b1};
    s[1] = mk(3'd7, 32'h1234, 32'h5678, 5'd9, 16'hFFFF);
    x[1] = '{32'd0, 32'd0, 1'b1};
    s[2] = mk(3'd0, 32'd3, 32'd4, 5'd0, 16'd0);
    x[2] = '{32'd3, 32'd4, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (io.out_valid !== 1'b1 || io.out_a !== e.a ||
          io.out_b !== e.b || io.out_err !== e.err) begin
        errors++;
        $display("FAIL illegal[%0d]: got v=%b a=%h b=%h err=%b, want v=1 a=%h b=%h err=%b",
                 i, io.out_valid, io.out_a, io.out_b, io.out_err, e.a, e.b, e.err);
      end
    end
    io.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    exp_t e;
    io.out_ready = 1'b1;
    drive(mk(3'd0, 32'h11, 32'h22, 5'd0, 16'd0));
    sb.push_back('{32'h11, 32'h22, 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if (io.out_valid !== 1'b1 || io.out_a !== e.a || io.out_b !== e.b) begin
      errors++;
      $display("FAIL stall_fill: got v=%b a=%h b=%h, want v=1 a=%h b=%h",
               io.out_valid, io.out_a, io.out_b, e.a, e.b);
    end
    io.out_ready = 1'b0;
    drive(mk(3'd1, 32'h33, 32'h44, 5'd0, 16'h55));
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (io.out_valid !== 1'b1 || io.out_a !== 32'h11 ||
          io.out_b !== 32'h22 || io.out_err !== 1'b0 ||
          io.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b a=%h b=%h err=%b rdy=%b, want 1 11 22 0 0",
                 k, io.out_valid, io.out_a, io.out_b, io.out_err, io.in_ready);
      end
    end
    io.out_ready = 1'b1;
    #1;
    checks++;
    if (io.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_ready: got in_ready=%b, want 1", io.in_ready);
    end
    sb.push_back('{32'h33, 32'h55, 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if (io.out_valid !== 1'b1 || io.out_a !== e.a || io.out_b !== e.b) begin
      errors++;
      $display("FAIL stall_next: got v=%b a=%h b=%h, want v=1 a=%h b=%h",
               io.out_valid, io.out_a, io.out_b, e.a, e.b);
    end
    io.in_valid = 1'b0;
    tick();
    checks++;
    if (io.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: got v=%b, want 0", io.out_valid);
    end
  endtask

  task automatic test_flush();
    exp_t e;
    drive(mk(3'd0, 32'h55, 32'h66, 5'd0, 16'd0));
    sb.push_back('{32'h55, 32'h66, 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if (io.out_valid !== 1'b1 || io.out_a !== e.a || io.out_b !== e.b) begin
      errors++;
      $display("FAIL flush_fill: got v=%b a=%h b=%h, want v=1 a=%h b=%h",
               io.out_valid, io.out_a, io.out_b, e.a, e.b);
    end
    io.flush = 1'b1;
    drive(mk(3'd0, 32'h77, 32'h88, 5'd0, 16'd0));
    tick();
    checks++;
    if (io.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_xfer: got v=%b, want 0", io.out_valid);
    end
    io.flush = 1'b0;
    drive(mk(3'd2, 32'h9, 32'h0, 5'd0, 16'h7FFF));
    sb.push_back('{32'h9, 32'h7FFF, 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if (io.out_valid !== 1'b1 || io.out_a !== e.a || io.out_b !== e.b) begin
      errors++;
      $display("FAIL flush_refill: got v=%b a=%h b=%h, want v=1 a=%h b=%h",
               io.out_valid, io.out_a, io.out_b, e.a, e.b);
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    io.flush = 1'b1;
    tick();
    checks++;
    if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_stalled: got v=%b rdy=%b, want 0 1",
               io.out_valid, io.in_ready);
    end
    io.flush = 1'b0;
    io.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_stall();
    exp_t e;
    drive(mk(3'd0, 32'h99, 32'hAA, 5'd0, 16'd0));
    sb.push_back('{32'h99, 32'hAA, 1'b0});
    tick();
    e = sb.pop_front();
    io.out_ready = 1'b0;
    io.in_valid = 1'b0;
    tick();
    checks++;
    if (io.out_valid !== 1'b1 || io.out_a !== e.a || io.out_b !== e.b) begin
      errors++;
      $display("FAIL rst_stall_hold: got v=%b a=%h b=%h, want v=1 a=%h b=%h",
               io.out_valid, io.out_a, io.out_b, e.a, e.b);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1 ||
        io.out_a !== 32'd0 || io.out_b !== 32'd0) begin
      errors++;
      $display("FAIL rst_stall_drop: got v=%b rdy=%b a=%h b=%h, want 0 1 0 0",
               io.out_valid, io.in_ready, io.out_a, io.out_b);
    end
    tick();
    rst_n = 1'b1;
    io.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t  e;
    stim_t s;
    io.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s = mk(3'($urandom_range(0, 7)), $urandom, $urandom,
             5'($urandom), 16'($urandom));
      s.rs = 5'($urandom_range(0, 3));
      s.rt = 5'($urandom_range(0, 3));
      s.ewe = 1'($urandom); s.ea = 5'($urandom_range(0, 3));
      s.ed = $urandom;
      s.wwe = 1'($urandom); s.wa = 5'($urandom_range(0, 3));
      s.wd = $urandom;
      drive(s);
      sb.push_back(model());
      tick();
      e = sb.pop_front();
      checks++;
      if (io.out_valid !== 1'b1 || io.out_a !== e.a ||
          io.out_b !== e.b || io.out_err !== e.err) begin
        errors++;
        $display("FAIL b2b[%0d]: got v=%b a=%h b=%h err=%b, want v=1 a=%h b=%h err=%b",
                 i, io.out_valid, io.out_a, io.out_b, io.out_err, e.a, e.b, e.err);
      end
    end
    io.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    io.flush = 1'b0;
    io.out_ready = 1'b1;
    drive(mk(3'd0, 32'd0, 32'd0, 5'd0, 16'd0));
    io.in_valid = 1'b0;
    test_reset();
    test_extension();
    test_shifts();
    test_forward();
    test_illegal();
    test_stall();
    test_flush();
    test_reset_stall();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
